// File: rtl/am2940_seq.sv
// ============================================================================
// am2940_seq
// ----------------------------------------------------------------------------
// Command sequencer that drives an Am2940 DMA address generator from the
// initiator side. It accepts a transfer request (control word, start address
// and word count) and programs the Am2940 through its instruction/data port.
// It writes the control register, then loads the address, then loads the
// word count. It then enables the Am2940 counters until the chip raises DONE
// or a cycle budget runs out. Every address the Am2940 steps past is
// presented downstream as one qualified transfer beat.
//
// Optional feature (compile-time macro AM2940_SEQ_REINIT_EN):
//   When defined, raising repeat_req during FINISH sends the sequencer
//   through REINIT. REINIT issues Am2940 instruction 100, which reloads the
//   counters from the chip's stored address/count registers, and the
//   sequencer then runs the same block again without reprogramming it.
//   When undefined, repeat_req is ignored and FINISH always returns to IDLE.
//
// Parameters
//   TIMEOUT     maximum RUN cycles (stalled or not) before the transfer is
//               abandoned with err set; must be >= 2
//
// Ports
//   TRANS       system clock, rising edge
//   res         asynchronous active-low reset
//   start       request strobe, only looked at in IDLE
//   cfg_ctrl    Am2940 control word (instruction 000), held while busy
//   cfg_addr    start address (instruction 101)
//   cfg_wcnt    word count (instruction 110), 0 is legal
//   repeat_req  replay request sampled in FINISH (macro build only)
//   stall       downstream back-pressure, pauses counting one edge later
//   DONE        Am2940 done flag
//   A_IN        Am2940 address output
//   I           Am2940 instruction
//   D_OUT       data to the Am2940 data input
//   nOEA        Am2940 address output enable, active-low
//   ACI / WCI   Am2940 address / word counter carry-in enables, active-low
//   xfer_valid  xfer_addr carries a live transfer beat
//   xfer_addr   registered copy of A_IN
//   busy        sequencer not in IDLE
//   done        one-cycle completion pulse (the FINISH cycle)
//   err         sticky timeout flag, cleared by the next accepted start
// ============================================================================
module am2940_seq #(
    parameter int TIMEOUT = 64
) (
    input  logic       TRANS,
    input  logic       res,
    input  logic       start,
    input  logic [2:0] cfg_ctrl,
    input  logic [3:0] cfg_addr,
    input  logic [3:0] cfg_wcnt,
    input  logic       repeat_req,
    input  logic       stall,
    input  logic       DONE,
    input  logic [3:0] A_IN,
    output logic [2:0] I,
    output logic [3:0] D_OUT,
    output logic       nOEA,
    output logic       ACI,
    output logic       WCI,
    output logic       xfer_valid,
    output logic [3:0] xfer_addr,
    output logic       busy,
    output logic       done,
    output logic       err
);

    // Am2940 instruction codes used by the sequencer
    localparam logic [2:0] INSTR_WR_CR   = 3'b000;
    localparam logic [2:0] INSTR_REINIT  = 3'b100;
    localparam logic [2:0] INSTR_LD_ADDR = 3'b101;
    localparam logic [2:0] INSTR_LD_WC   = 3'b110;
    localparam logic [2:0] INSTR_ENCNT   = 3'b111;

    // Timeout counter sizing: the counter only has to reach TIMEOUT-1
    localparam int             TW   = $clog2(TIMEOUT);
    localparam logic [TW-1:0]  TLIM = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_CR   = 3'd1,
        S_LD_ADDR = 3'd2,
        S_LD_WC   = 3'd3,
        S_RUN     = 3'd4,
        S_FINISH  = 3'd5,
        S_REINIT  = 3'd6
    } state_t;

    state_t        r_state;
    state_t        w_next;

    logic [3:0]    r_addr;
    logic [3:0]    r_wcnt;
    logic [TW-1:0] r_tcnt;
    logic          w_timeout;

    // Next-cycle values of the registered outputs
    logic [2:0]    w_i;
    logic [3:0]    w_dout;
    logic          w_noea;
    logic          w_cnt_n;
    logic          w_busy;
    logic          w_done;

    // Output registers
    logic [2:0]    r_i;
    logic [3:0]    r_dout;
    logic          r_noea;
    logic          r_cnt_n;
    logic          r_xvalid;
    logic [3:0]    r_xaddr;
    logic          r_busy;
    logic          r_done;
    logic          r_err;

`ifndef AM2940_SEQ_REINIT_EN
    // repeat_req has no function in this build
    logic w_unused_repeat;
    assign w_unused_repeat = repeat_req;
`endif

    // The budget is spent once the counter sits at TIMEOUT-1 during RUN
    assign w_timeout = (r_tcnt == TLIM);

    // State register
    always_ff @(posedge TRANS or negedge res) begin
        if (!res) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: programming is a fixed three-step walk, RUN exits on
    // DONE or an exhausted budget, FINISH optionally loops back via REINIT
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (start) w_next = S_WR_CR;
            S_WR_CR:   w_next = S_LD_ADDR;
            S_LD_ADDR: w_next = S_LD_WC;
            S_LD_WC:   w_next = S_RUN;
            S_RUN:     if (DONE || w_timeout) w_next = S_FINISH;
`ifdef AM2940_SEQ_REINIT_EN
            S_FINISH:  w_next = repeat_req ? S_REINIT : S_IDLE;
`else
            S_FINISH:  w_next = S_IDLE;
`endif
            S_REINIT:  w_next = S_RUN;
            default:   w_next = S_IDLE;
        endcase
    end

    // Output decode from the state being entered, so that every output can
    // be registered and still line up with its state. The WR_CR data comes
    // straight from cfg_ctrl because the requester holds it while busy; the
    // address and count are taken from the copies latched at start.
    always_comb begin
        w_i     = INSTR_ENCNT;
        w_dout  = 4'd0;
        w_noea  = 1'b1;
        w_cnt_n = 1'b1;
        w_busy  = (w_next != S_IDLE);
        w_done  = 1'b0;
        case (w_next)
            S_WR_CR: begin
                w_i    = INSTR_WR_CR;
                w_dout = {1'b0, cfg_ctrl};
            end
            S_LD_ADDR: begin
                w_i    = INSTR_LD_ADDR;
                w_dout = r_addr;
            end
            S_LD_WC: begin
                w_i    = INSTR_LD_WC;
                w_dout = r_wcnt;
            end
            S_RUN: begin
                w_noea  = 1'b0;
                w_cnt_n = stall;
            end
            S_FINISH: begin
                w_done = 1'b1;
            end
            S_REINIT: begin
                w_i = INSTR_REINIT;
            end
            default: begin
                w_i = INSTR_ENCNT;
            end
        endcase
    end

    // Request latch: address and count are captured on an accepted start
    always_ff @(posedge TRANS or negedge res) begin
        if (!res) begin
            r_addr <= 4'd0;
            r_wcnt <= 4'd0;
        end else if (r_state == S_IDLE && start) begin
            r_addr <= cfg_addr;
            r_wcnt <= cfg_wcnt;
        end
    end

    // Timeout counter: cleared on every entry into RUN, counts each RUN
    // cycle including stalled ones, and parks at TIMEOUT-1
    always_ff @(posedge TRANS or negedge res) begin
        if (!res) begin
            r_tcnt <= '0;
        end else if (w_next == S_RUN && r_state != S_RUN) begin
            r_tcnt <= '0;
        end else if (r_state == S_RUN && r_tcnt != TLIM) begin
            r_tcnt <= r_tcnt + TW'(1);
        end
    end

    // Sticky error: cleared by an accepted start, set when RUN ends on the
    // budget alone (a DONE seen in the same cycle takes priority)
    always_ff @(posedge TRANS or negedge res) begin
        if (!res) begin
            r_err <= 1'b0;
        end else if (r_state == S_IDLE && start) begin
            r_err <= 1'b0;
        end else if (r_state == S_RUN && !DONE && w_timeout) begin
            r_err <= 1'b1;
        end
    end

    // Registered Am2940 controls and status
    always_ff @(posedge TRANS or negedge res) begin
        if (!res) begin
            r_i     <= INSTR_ENCNT;
            r_dout  <= 4'd0;
            r_noea  <= 1'b1;
            r_cnt_n <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_i     <= w_i;
            r_dout  <= w_dout;
            r_noea  <= w_noea;
            r_cnt_n <= w_cnt_n;
            r_busy  <= w_busy;
            r_done  <= w_done;
        end
    end

    // Beat stage: the address the Am2940 shows during a counting RUN cycle
    // is the one it steps past at the following edge, so that address is
    // captured together with a valid flag. Each address is therefore
    // emitted exactly once, and a stalled cycle produces no beat.
    always_ff @(posedge TRANS or negedge res) begin
        if (!res) begin
            r_xvalid <= 1'b0;
            r_xaddr  <= 4'd0;
        end else begin
            r_xvalid <= (r_state == S_RUN) && !r_cnt_n;
            r_xaddr  <= A_IN;
        end
    end

    assign I          = r_i;
    assign D_OUT      = r_dout;
    assign nOEA       = r_noea;
    assign ACI        = r_cnt_n;
    assign WCI        = r_cnt_n;
    assign xfer_valid = r_xvalid;
    assign xfer_addr  = r_xaddr;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;

endmodule

// File: tb/tb_am2940_seq.sv
// Directed bench for am2940_seq. A small behavioural Am2940 (load/count/
// reinit, DONE while the word counter reads 1) sits on the instruction
// port, so the transfer beats come from a real counting sequence.
module tb_am2940_seq;

    logic       clock = 1'b0;
    logic       resN;
    logic       start;
    logic [2:0] cfgCtrl;
    logic [3:0] cfgAddr;
    logic [3:0] cfgWcnt;
    logic       repeatReq;
    logic       stall;
    logic       doneIn;
    logic [3:0] aIn;
    logic [2:0] instr;
    logic [3:0] dOut;
    logic       nOEA;
    logic       aci;
    logic       wci;
    logic       xferValid;
    logic [3:0] xferAddr;
    logic       busy;
    logic       done;
    logic       err;

    int vectors     = 0;
    int miscompares = 0;
    int tickCount   = 0;
    int tStart      = 0;
    int runCycles   = 0;
    int stallCycles = 0;
    logic [3:0] beats[$];

    // Behavioural Am2940 model
    logic       tieDoneLow = 1'b0;
    logic [3:0] mAddrReg   = 4'd0;
    logic [3:0] mWcReg     = 4'd0;
    logic [3:0] mAddrCnt   = 4'd0;
    logic [3:0] mWcCnt     = 4'd0;

    always #5 clock = ~clock;

    am2940_seq #(.TIMEOUT(8)) dut (
        .TRANS      (clock),
        .res        (resN),
        .start      (start),
        .cfg_ctrl   (cfgCtrl),
        .cfg_addr   (cfgAddr),
        .cfg_wcnt   (cfgWcnt),
        .repeat_req (repeatReq),
        .stall      (stall),
        .DONE       (doneIn),
        .A_IN       (aIn),
        .I          (instr),
        .D_OUT      (dOut),
        .nOEA       (nOEA),
        .ACI        (aci),
        .WCI        (wci),
        .xfer_valid (xferValid),
        .xfer_addr  (xferAddr),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    // Am2940: 101 loads address register and counter, 110 loads word count
    // register and counter, 100 reloads both counters, 111 counts when the
    // active-low carry-ins are asserted
    always @(posedge clock) begin
        case (instr)
            3'b101: begin mAddrReg <= dOut; mAddrCnt <= dOut; end
            3'b110: begin mWcReg <= dOut; mWcCnt <= dOut; end
            3'b100: begin mAddrCnt <= mAddrReg; mWcCnt <= mWcReg; end
            3'b111: begin
                if (!aci) mAddrCnt <= mAddrCnt + 4'd1;
                if (!wci) mWcCnt <= mWcCnt - 4'd1;
            end
            default: ;
        endcase
    end

    assign doneIn = tieDoneLow ? 1'b0 : (mWcCnt == 4'd1);
    assign aIn    = mAddrCnt;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One clock: sample 1 time unit after the rising edge and log beats
    task automatic tick();
        @(posedge clock);
        #1;
        tickCount++;
        if (xferValid) beats.push_back(xferAddr);
        if (!nOEA) begin
            runCycles++;
            if (aci) stallCycles++;
        end
    endtask

    task automatic applyStimulus(input logic [2:0] c, input logic [3:0] a,
                                 input logic [3:0] w);
        cfgCtrl = c;
        cfgAddr = a;
        cfgWcnt = w;
        start   = 1'b1;
    endtask

    // Wait for the done pulse and verify its cycle (counted from the start
    // edge), the beat sequence, RUN length and err in the FINISH cycle
    task automatic finishRun(input int expDone, input int expBeats,
                             input logic [3:0] firstAddr, input int expRun,
                             input logic expErr, input string tag);
        logic [3:0] want;
        while (!done && (tickCount - tStart) < 60) tick();
        checkOutput({tag, "_doneCycle"}, tickCount - tStart, expDone);
        checkOutput({tag, "_busyFinish"}, busy, 1'b1);
        checkOutput({tag, "_err"}, err, expErr);
        checkOutput({tag, "_runCycles"}, runCycles, expRun);
        checkOutput({tag, "_beatCount"}, beats.size(), expBeats);
        want = firstAddr;
        for (int k = 0; k < beats.size() && k < expBeats; k++) begin
            checkOutput({tag, "_beat"}, beats[k], want);
            want = want + 4'd1;
        end
    endtask

    task automatic runTransfer(input logic [2:0] c, input logic [3:0] a,
                               input logic [3:0] w, input bit doStall,
                               input bit pokeStart, input int expDone,
                               input int expBeats, input int expRun,
                               input logic expErr, input string tag);
        beats.delete();
        runCycles   = 0;
        stallCycles = 0;
        tStart      = tickCount;
        applyStimulus(c, a, w);
        tick();
        start = 1'b0;
        checkOutput({tag, "_wrcrI"}, instr, 3'b000);
        checkOutput({tag, "_wrcrD"}, dOut, {1'b0, c});
        checkOutput({tag, "_busy"}, busy, 1'b1);
        checkOutput({tag, "_errClr"}, err, 1'b0);
        tick();
        if (pokeStart) start = 1'b1;
        checkOutput({tag, "_ldaI"}, instr, 3'b101);
        checkOutput({tag, "_ldaD"}, dOut, a);
        tick();
        start = 1'b0;
        checkOutput({tag, "_ldwI"}, instr, 3'b110);
        checkOutput({tag, "_ldwD"}, dOut, w);
        tick();
        checkOutput({tag, "_runI"}, instr, 3'b111);
        checkOutput({tag, "_runAci"}, {aci, wci, nOEA}, 3'b000);
        if (doStall) begin
            stall = 1'b1;
            tick();
            checkOutput({tag, "_stallAci"}, {aci, wci}, 2'b11);
            tick();
            stall = 1'b0;
            checkOutput({tag, "_stallCycles"}, stallCycles, 2);
        end
        finishRun(expDone, expBeats, a, expRun, expErr, tag);
    endtask

    task automatic finishToIdle(input string tag);
        tick();
        checkOutput({tag, "_doneOnce"}, done, 1'b0);
        checkOutput({tag, "_idleBusy"}, busy, 1'b0);
        checkOutput({tag, "_idleI"}, instr, 3'b111);
    endtask

    initial begin
        resN      = 1'b0;
        start     = 1'b0;
        cfgCtrl   = 3'd0;
        cfgAddr   = 4'd0;
        cfgWcnt   = 4'd0;
        repeatReq = 1'b0;
        stall     = 1'b0;

        // Reset values, then three idle cycles with no change
        tick();
        tick();
        checkOutput("rstI", instr, 3'b111);
        checkOutput("rstCtl", {nOEA, aci, wci, busy, done, err, xferValid}, 7'b1110000);
        checkOutput("rstData", {dOut, xferAddr}, 8'h00);
        resN = 1'b1;
        tick();
        tick();
        tick();
        checkOutput("idleI", instr, 3'b111);
        checkOutput("idleCtl", {nOEA, aci, wci, busy, done, err}, 6'b111000);

        // Plain transfer 5 x 3 -> beats 5,6,7, done in cycle 7
        runTransfer(3'd0, 4'd5, 4'd3, 1'b0, 1'b0, 7, 3, 3, 1'b0, "xfer");
        finishToIdle("xfer");

        // Two stalled cycles: same beats, two cycles later
        runTransfer(3'd0, 4'd5, 4'd3, 1'b1, 1'b0, 9, 3, 5, 1'b0, "stall");
        finishToIdle("stall");

        // Different control word, start poked while busy is ignored
        runTransfer(3'b101, 4'd2, 4'd2, 1'b0, 1'b1, 6, 2, 2, 1'b0, "poke");
        finishToIdle("poke");

        // Address wrap E,F,0
        runTransfer(3'b111, 4'hE, 4'd3, 1'b0, 1'b0, 7, 3, 3, 1'b0, "wrap");
        finishToIdle("wrap");

        // Timeout with DONE tied low: 8 RUN cycles, err set and sticky
        tieDoneLow = 1'b1;
        runTransfer(3'd0, 4'd1, 4'd3, 1'b0, 1'b0, 12, 8, 8, 1'b1, "tmo");
        finishToIdle("tmo");
        tick();
        tick();
        checkOutput("tmoSticky", err, 1'b1);
        tieDoneLow = 1'b0;

        // DONE in the last budget cycle wins: no err, err cleared at start
        runTransfer(3'd0, 4'd0, 4'd8, 1'b0, 1'b0, 12, 8, 8, 1'b0, "tie");
        finishToIdle("tie");

        // Asynchronous reset in the middle of RUN
        beats.delete();
        tStart = tickCount;
        applyStimulus(3'd0, 4'd5, 4'd3);
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        checkOutput("preRstBeat", {xferValid, xferAddr}, 5'h15);
        #2;
        resN = 1'b0;
        #1;
        checkOutput("asyncI", instr, 3'b111);
        checkOutput("asyncCtl", {nOEA, aci, wci, busy, done, err, xferValid}, 7'b1110000);
        checkOutput("asyncData", {dOut, xferAddr}, 8'h00);
        tick();
        resN = 1'b1;
        tick();
        checkOutput("postRstBusy", busy, 1'b0);

`ifdef AM2940_SEQ_REINIT_EN
        // Replay through REINIT: instruction 100 once, then 5,6,7 again
        repeatReq = 1'b1;
        runTransfer(3'd0, 4'd5, 4'd3, 1'b0, 1'b0, 7, 3, 3, 1'b0, "rep1");
        tick();
        checkOutput("reinitI", instr, 3'b100);
        checkOutput("reinitBusy", {busy, done}, 2'b10);
        repeatReq   = 1'b0;
        beats.delete();
        runCycles   = 0;
        tStart      = tickCount - 3;
        finishRun(7, 3, 4'd5, 3, 1'b0, "rep2");
        finishToIdle("rep2");
`else
        // Without the replay feature repeat_req has no effect
        repeatReq = 1'b1;
        runTransfer(3'd0, 4'd5, 4'd3, 1'b0, 1'b0, 7, 3, 3, 1'b0, "norep");
        finishToIdle("norep");
        repeatReq = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
